// File: rtl/dcache_fill_controller.sv
// Memory-side fill/write-back engine for the data cache. Each channel claims one consumer,
// streams its block as single-word beats, and relays the completed block back to it.
module dcache_fill_controller #(
  parameter int ADDR_BITS        = 8,
  parameter int DATA_BITS        = 8,
  parameter int NUM_CONSUMERS    = 4,
  parameter int NUM_CHANNELS     = 2,
  parameter int CACHE_BLOCK_SIZE = 4
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic [NUM_CONSUMERS-1:0]                     cache_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]           cache_read_address,
  output logic [NUM_CONSUMERS-1:0]                     cache_read_ready,
  output logic [NUM_CONSUMERS*CACHE_BLOCK_SIZE*DATA_BITS-1:0] cache_read_data,
  input  logic [NUM_CONSUMERS-1:0]                     cache_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]           cache_write_address,
  input  logic [NUM_CONSUMERS*CACHE_BLOCK_SIZE*DATA_BITS-1:0] cache_write_data,
  output logic [NUM_CONSUMERS-1:0]                     cache_write_ready,
  output logic [NUM_CHANNELS-1:0]                      mem_read_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]            mem_read_address,
  input  logic [NUM_CHANNELS-1:0]                      mem_read_ready,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0]            mem_read_data,
  output logic [NUM_CHANNELS-1:0]                      mem_write_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]            mem_write_address,
  output logic [NUM_CHANNELS*DATA_BITS-1:0]            mem_write_data,
  input  logic [NUM_CHANNELS-1:0]                      mem_write_ready
);
  localparam int BLOCK_BITS = CACHE_BLOCK_SIZE * DATA_BITS;
  localparam int CNT_W      = (CACHE_BLOCK_SIZE > 1) ? $clog2(CACHE_BLOCK_SIZE) : 1;
  localparam int CONS_W     = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
  localparam logic [ADDR_BITS-1:0] BASE_MASK = ~ADDR_BITS'(CACHE_BLOCK_SIZE - 1);
  localparam logic [CNT_W-1:0]     LAST_BEAT = CNT_W'(CACHE_BLOCK_SIZE - 1);

  typedef enum logic [2:0] {
    IDLE, READ_WAITING, WRITE_WAITING, READ_RELAYING, WRITE_RELAYING
  } chan_state_t;

  chan_state_t                 state_q [NUM_CHANNELS];
  chan_state_t                 state_d [NUM_CHANNELS];
  logic [CONS_W-1:0]           cons_q  [NUM_CHANNELS];
  logic [ADDR_BITS-1:0]        base_q  [NUM_CHANNELS];
  logic [CNT_W-1:0]            cnt_q   [NUM_CHANNELS];
  logic [BLOCK_BITS-1:0]       wblk_q  [NUM_CHANNELS];
  logic [BLOCK_BITS-1:0]       rblk_q  [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]     relay_ready_q;

  logic [NUM_CONSUMERS-1:0]    claimed;
  logic [NUM_CHANNELS-1:0]     grant_valid;
  logic [NUM_CHANNELS-1:0]     grant_write;
  logic [CONS_W-1:0]           grant_idx [NUM_CHANNELS];

  // Arbitration: idle channels in ascending order take the lowest unclaimed requester;
  // claims made by lower channels this cycle are visible to higher ones. Writes win ties.
  always_comb begin
    claimed     = '0;
    grant_valid = '0;
    grant_write = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      grant_idx[c] = '0;
      if (state_q[c] != IDLE) claimed[cons_q[c]] = 1'b1;
    end
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (state_q[c] == IDLE) begin
        for (int k = 0; k < NUM_CONSUMERS; k++) begin
          if (!grant_valid[c] && !claimed[k] && (cache_read_valid[k] || cache_write_valid[k])) begin
            grant_valid[c] = 1'b1;
            grant_write[c] = cache_write_valid[k];
            grant_idx[c]   = CONS_W'(k);
            claimed[k]     = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (reset) state_q[c] <= IDLE;
      else       state_q[c] <= state_d[c];
    end
  end

  // A memory beat completes on a rising edge where the channel's valid and the memory's ready
  // are both high; valid and address stay put until then. Cache requests are held by the
  // consumer until the relayed ready is seen, then dropped to release the channel.
  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      state_d[c] = state_q[c];
      case (state_q[c])
        IDLE:           if (grant_valid[c]) state_d[c] = grant_write[c] ? WRITE_WAITING : READ_WAITING;
        READ_WAITING:   if (mem_read_ready[c] && cnt_q[c] == LAST_BEAT) state_d[c] = READ_RELAYING;
        WRITE_WAITING:  if (mem_write_ready[c] && cnt_q[c] == LAST_BEAT) state_d[c] = WRITE_RELAYING;
        READ_RELAYING:  if (!cache_read_valid[cons_q[c]]) state_d[c] = IDLE;
        WRITE_RELAYING: if (!cache_write_valid[cons_q[c]]) state_d[c] = IDLE;
        default:        state_d[c] = IDLE;
      endcase
    end
  end

  always_comb begin
    mem_read_valid    = '0;
    mem_read_address  = '0;
    mem_write_valid   = '0;
    mem_write_address = '0;
    mem_write_data    = '0;
    cache_read_ready  = '0;
    cache_read_data   = '0;
    cache_write_ready = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (state_q[c] == READ_WAITING) begin
        mem_read_valid[c] = 1'b1;
        mem_read_address[c*ADDR_BITS +: ADDR_BITS] = base_q[c] + ADDR_BITS'(cnt_q[c]);
      end
      if (state_q[c] == WRITE_WAITING) begin
        mem_write_valid[c] = 1'b1;
        mem_write_address[c*ADDR_BITS +: ADDR_BITS] = base_q[c] + ADDR_BITS'(cnt_q[c]);
        mem_write_data[c*DATA_BITS +: DATA_BITS] = wblk_q[c][cnt_q[c]*DATA_BITS +: DATA_BITS];
      end
      if (state_q[c] == READ_RELAYING && relay_ready_q[c]) begin
        cache_read_ready[cons_q[c]] = 1'b1;
        cache_read_data[cons_q[c]*BLOCK_BITS +: BLOCK_BITS] = rblk_q[c];
      end
      if (state_q[c] == WRITE_RELAYING && relay_ready_q[c]) cache_write_ready[cons_q[c]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (reset) begin
        cons_q[c]        <= '0;
        base_q[c]        <= '0;
        cnt_q[c]         <= '0;
        wblk_q[c]        <= '0;
        rblk_q[c]        <= '0;
        relay_ready_q[c] <= 1'b0;
      end else begin
        case (state_q[c])
          IDLE: begin
            relay_ready_q[c] <= 1'b0;
            if (grant_valid[c]) begin
              cons_q[c] <= grant_idx[c];
              base_q[c] <= (grant_write[c] ? cache_write_address[grant_idx[c]*ADDR_BITS +: ADDR_BITS]
                                           : cache_read_address[grant_idx[c]*ADDR_BITS +: ADDR_BITS]) & BASE_MASK;
              wblk_q[c] <= cache_write_data[grant_idx[c]*BLOCK_BITS +: BLOCK_BITS];
              cnt_q[c]  <= '0;
            end
          end
          READ_WAITING: if (mem_read_ready[c]) begin
            rblk_q[c][cnt_q[c]*DATA_BITS +: DATA_BITS] <= mem_read_data[c*DATA_BITS +: DATA_BITS];
            if (cnt_q[c] != LAST_BEAT) cnt_q[c] <= cnt_q[c] + CNT_W'(1);
          end
          WRITE_WAITING: if (mem_write_ready[c] && cnt_q[c] != LAST_BEAT) cnt_q[c] <= cnt_q[c] + CNT_W'(1);
          // Ready is raised one cycle into relaying and falls as soon as the consumer lets go.
          READ_RELAYING:  relay_ready_q[c] <= cache_read_valid[cons_q[c]];
          WRITE_RELAYING: relay_ready_q[c] <= cache_write_valid[cons_q[c]];
          default:        relay_ready_q[c] <= 1'b0;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_dcache_fill_controller.sv
// Directed bench for dcache_fill_controller: cycle table for a basic fill, then hand-written
// sequences for stalls, channel contention, write-then-read, mid-transfer reset and 1-word blocks.
module tb_dcache_fill_controller;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // main instance: 4 consumers, 2 channels, 4-word blocks
  logic [3:0]   crv, cwv, crr, cwr;
  logic [31:0]  cra, cwa;
  logic [127:0] crd, cwd;
  logic [1:0]   mrv, mwv, mrr, mwr;
  logic [15:0]  mra, mwa, mwd, mrd;

  dcache_fill_controller #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4), .NUM_CHANNELS(2),
                           .CACHE_BLOCK_SIZE(4)) dut (
    .clk(clk), .reset(reset),
    .cache_read_valid(crv), .cache_read_address(cra), .cache_read_ready(crr), .cache_read_data(crd),
    .cache_write_valid(cwv), .cache_write_address(cwa), .cache_write_data(cwd), .cache_write_ready(cwr),
    .mem_read_valid(mrv), .mem_read_address(mra), .mem_read_ready(mrr), .mem_read_data(mrd),
    .mem_write_valid(mwv), .mem_write_address(mwa), .mem_write_data(mwd), .mem_write_ready(mwr));

  // second instance with single-word blocks
  logic [3:0]  b_crv, b_cwv, b_crr, b_cwr;
  logic [31:0] b_cra, b_cwa, b_crd, b_cwd;
  logic [1:0]  b_mrv, b_mwv, b_mrr, b_mwr;
  logic [15:0] b_mra, b_mwa, b_mwd, b_mrd;

  dcache_fill_controller #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4), .NUM_CHANNELS(2),
                           .CACHE_BLOCK_SIZE(1)) dut_b (
    .clk(clk), .reset(reset),
    .cache_read_valid(b_crv), .cache_read_address(b_cra), .cache_read_ready(b_crr), .cache_read_data(b_crd),
    .cache_write_valid(b_cwv), .cache_write_address(b_cwa), .cache_write_data(b_cwd), .cache_write_ready(b_cwr),
    .mem_read_valid(b_mrv), .mem_read_address(b_mra), .mem_read_ready(b_mrr), .mem_read_data(b_mrd),
    .mem_write_valid(b_mwv), .mem_write_address(b_mwa), .mem_write_data(b_mwd), .mem_write_ready(b_mwr));

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // ---------------- memory model for the main instance ----------------
  logic [7:0]  mem [256];
  int          stall = 0;
  int          stab_err = 0;
  int          wait_c [2];
  logic        rdy_pend [2];
  logic        pend_w [2];
  logic [7:0]  rec_a [2], rec_d [2], hold_a [2], hold_d [2];
  logic        cur_w;
  logic [7:0]  cur_a, cur_d;
  logic [16:0] got_q [$];
  logic [16:0] exp_q [$];

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 8'(a) ^ 8'h5A;
    mrr = '0; mwr = '0; mrd = '0;
    for (int c = 0; c < 2; c++) begin wait_c[c] = 0; rdy_pend[c] = 1'b0; end
  end

  // Acts just after each rising edge: retires the beat that handshook on that edge,
  // then decides ready for the next edge after `stall` waiting cycles per beat.
  always @(posedge clk) begin
    #1;
    if (reset) begin
      for (int c = 0; c < 2; c++) begin
        wait_c[c] = 0; rdy_pend[c] = 1'b0; mrr[c] = 1'b0; mwr[c] = 1'b0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (rdy_pend[c]) begin
          if (pend_w[c]) mem[rec_a[c]] = rec_d[c];
          got_q.push_back({pend_w[c], rec_a[c], rec_d[c]});
          rdy_pend[c] = 1'b0;
          wait_c[c] = 0;
        end
        mrr[c] = 1'b0;
        mwr[c] = 1'b0;
        if (mrv[c] || mwv[c]) begin
          cur_w = mwv[c];
          cur_a = cur_w ? mwa[c*8 +: 8] : mra[c*8 +: 8];
          cur_d = cur_w ? mwd[c*8 +: 8] : mem[cur_a];
          if (wait_c[c] == 0) begin
            hold_a[c] = cur_a; hold_d[c] = cur_d;
          end else if (cur_a != hold_a[c] || (cur_w && cur_d != hold_d[c])) begin
            stab_err++;
          end
          if (wait_c[c] >= stall) begin
            if (cur_w) mwr[c] = 1'b1;
            else begin mrr[c] = 1'b1; mrd[c*8 +: 8] = cur_d; end
            rdy_pend[c] = 1'b1; pend_w[c] = cur_w; rec_a[c] = cur_a; rec_d[c] = cur_d;
          end else begin
            wait_c[c]++;
          end
        end
      end
    end
  end

  function automatic logic [31:0] blk_exp(input logic [7:0] base);
    logic [31:0] v;
    for (int k = 0; k < 4; k++) v[k*8 +: 8] = (base + 8'(k)) ^ 8'h5A;
    return v;
  endfunction

  task automatic wait_bit(input string name, input bit is_write, input int k, input int budget);
    int   n = 0;
    logic seen = 1'b0;
    while (!seen && n < budget) begin
      @(negedge clk);
      seen = is_write ? cwr[k] : crr[k];
      n++;
    end
    check(name, {31'b0, seen}, 32'd1);
  endtask

  task automatic drain_scoreboard(input string name);
    logic [16:0] g, e;
    check({name, "_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      check(name, {15'b0, g}, {15'b0, e});
    end
    exp_q.delete();
    got_q.delete();
  endtask

  typedef struct {
    logic        rv;
    logic        exp_mv;
    logic [7:0]  exp_ma;
    logic        exp_rdy;
    logic [31:0] exp_data;
  } vec_t;
  vec_t vt [9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // row i: input applied before rising edge i, outputs expected after it
    vt[0] = '{1'b1, 1'b1, 8'h24, 1'b0, 32'h0};
    vt[1] = '{1'b1, 1'b1, 8'h25, 1'b0, 32'h0};
    vt[2] = '{1'b1, 1'b1, 8'h26, 1'b0, 32'h0};
    vt[3] = '{1'b1, 1'b1, 8'h27, 1'b0, 32'h0};
    vt[4] = '{1'b1, 1'b0, 8'h00, 1'b0, 32'h0};
    vt[5] = '{1'b1, 1'b0, 8'h00, 1'b1, 32'h44332211};
    vt[6] = '{1'b1, 1'b0, 8'h00, 1'b1, 32'h44332211};
    vt[7] = '{1'b0, 1'b0, 8'h00, 1'b0, 32'h0};
    vt[8] = '{1'b0, 1'b0, 8'h00, 1'b0, 32'h0};

    reset = 1'b1;
    crv = '0; cwv = '0; cra = '0; cwa = '0; cwd = '0;
    b_crv = '0; b_cwv = '0; b_cra = '0; b_cwa = '0; b_cwd = '0; b_mrr = '0; b_mwr = '0; b_mrd = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {31'b0, |{crr, cwr, crd, mrv, mwv, mra, mwa, mwd}}, 32'd0);
    check("reset_outputs_b", {31'b0, |{b_crr, b_cwr, b_crd, b_mrv, b_mwv, b_mra, b_mwa, b_mwd}}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // basic fill, zero-wait memory
    mem[8'h24] = 8'h11; mem[8'h25] = 8'h22; mem[8'h26] = 8'h33; mem[8'h27] = 8'h44;
    stall = 0;
    cra[7:0] = 8'h26;
    for (int i = 0; i < 9; i++) begin
      crv[0] = vt[i].rv;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("fill_mrv_%0d", i), {31'b0, mrv[0]}, {31'b0, vt[i].exp_mv});
      check($sformatf("fill_addr_%0d", i), {24'b0, mra[7:0]}, {24'b0, vt[i].exp_ma});
      check($sformatf("fill_rdy_%0d", i), {31'b0, crr[0]}, {31'b0, vt[i].exp_rdy});
      check($sformatf("fill_data_%0d", i), crd[31:0], vt[i].exp_data);
      check($sformatf("fill_mwv_%0d", i), {30'b0, mwv}, 32'd0);
    end
    got_q.delete();

    // write-back with two stall cycles per beat
    stall = 2;
    exp_q.push_back({1'b1, 8'h40, 8'hAA}); exp_q.push_back({1'b1, 8'h41, 8'hBB});
    exp_q.push_back({1'b1, 8'h42, 8'hCC}); exp_q.push_back({1'b1, 8'h43, 8'hDD});
    cwa[15:8] = 8'h40; cwd[63:32] = 32'hDDCCBBAA; cwv[1] = 1'b1;
    wait_bit("wb_ready", 1'b1, 1, 60);
    drain_scoreboard("wb_beat");
    check("wb_stable", stab_err, 0);
    @(negedge clk);
    check("wb_ready_hold", {31'b0, cwr[1]}, 32'd1);
    cwv[1] = 1'b0;
    @(negedge clk);
    check("wb_ready_drop", {31'b0, cwr[1]}, 32'd0);
    check("wb_mem", {24'b0, mem[8'h42]}, 32'h0000_00CC);

    // three simultaneous fills on two channels
    stall = 0;
    cra[7:0] = 8'h00; cra[15:8] = 8'h13; cra[23:16] = 8'h21;
    crv[2:0] = 3'b111;
    @(negedge clk);
    check("arb_ch0", {23'b0, mrv[0], mra[7:0]}, {23'b0, 1'b1, 8'h00});
    check("arb_ch1", {23'b0, mrv[1], mra[15:8]}, {23'b0, 1'b1, 8'h10});
    wait_bit("arb_c0_ready", 1'b0, 0, 20);
    check("arb_c1_ready", {31'b0, crr[1]}, 32'd1);
    check("arb_c0_data", crd[31:0], blk_exp(8'h00));
    check("arb_c1_data", crd[63:32], blk_exp(8'h10));
    crv[0] = 1'b0;
    @(negedge clk);
    check("arb_c0_release", {29'b0, crr[2:0]}, 32'b010);
    @(negedge clk);
    check("arb_c2_on_ch0", {22'b0, mrv, mra[7:0]}, {22'b0, 2'b01, 8'h20});
    check("arb_c1_still", {31'b0, crr[1]}, 32'd1);
    crv[1] = 1'b0;
    wait_bit("arb_c2_ready", 1'b0, 2, 20);
    check("arb_c2_data", crd[95:64], blk_exp(8'h20));
    crv[2] = 1'b0;
    @(negedge clk);
    got_q.delete();

    // consumer 3: write-back and fill of the same block together
    stall = 1;
    cwa[31:24] = 8'h80; cra[31:24] = 8'h82; cwd[127:96] = 32'h0F1E2D3C;
    cwv[3] = 1'b1; crv[3] = 1'b1;
    wait_bit("wr_first_ready", 1'b1, 3, 60);
    check("wr_first_count", got_q.size(), 4);
    for (int i = 0; i < 4; i++) check($sformatf("wr_first_kind_%0d", i), {31'b0, got_q[i][16]}, 32'd1);
    check("wr_first_no_read", {31'b0, crr[3]}, 32'd0);
    exp_q.push_back({1'b1, 8'h80, 8'h3C}); exp_q.push_back({1'b1, 8'h81, 8'h2D});
    exp_q.push_back({1'b1, 8'h82, 8'h1E}); exp_q.push_back({1'b1, 8'h83, 8'h0F});
    exp_q.push_back({1'b0, 8'h80, 8'h3C}); exp_q.push_back({1'b0, 8'h81, 8'h2D});
    exp_q.push_back({1'b0, 8'h82, 8'h1E}); exp_q.push_back({1'b0, 8'h83, 8'h0F});
    cwv[3] = 1'b0;
    wait_bit("wr_then_rd_ready", 1'b0, 3, 60);
    check("wr_then_rd_data", crd[127:96], 32'h0F1E2D3C);
    drain_scoreboard("wr_then_rd_beat");
    crv[3] = 1'b0;
    @(negedge clk);

    // reset after two of four read beats
    stall = 0;
    cra[23:16] = 8'h30; crv[2] = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_mid_no_ready", {28'b0, crr}, 32'd0);
    reset = 1'b1; crv[2] = 1'b0;
    @(negedge clk);
    check("rst_mid_outputs", {31'b0, |{crr, cwr, crd, mrv, mwv, mra, mwa, mwd}}, 32'd0);
    reset = 1'b0;
    got_q.delete();
    @(negedge clk);
    check("rst_after_idle", {30'b0, mrv}, 32'd0);
    cra[23:16] = 8'h31; crv[2] = 1'b1;
    wait_bit("rst_refill_ready", 1'b0, 2, 20);
    check("rst_refill_data", crd[95:64], blk_exp(8'h30));
    check("rst_refill_count", got_q.size(), 4);
    check("rst_refill_beat0", {15'b0, got_q[0]}, {15'b0, 1'b0, 8'h30, 8'h30 ^ 8'h5A});
    crv[2] = 1'b0;
    @(negedge clk);

    // single-word blocks
    b_cra[7:0] = 8'h07; b_crv[0] = 1'b1;
    @(negedge clk);
    check("blk1_beat", {23'b0, b_mrv[0], b_mra[7:0]}, {23'b0, 1'b1, 8'h07});
    b_mrr[0] = 1'b1; b_mrd[7:0] = 8'h9C;
    @(negedge clk);
    check("blk1_valid_drop", {31'b0, b_mrv[0]}, 32'd0);
    b_mrr[0] = 1'b0; b_mrd[7:0] = 8'h00;
    @(negedge clk);
    check("blk1_ready", {31'b0, b_crr[0]}, 32'd1);
    check("blk1_data", b_crd[7:0], 32'h9C);
    b_crv[0] = 1'b0;
    @(negedge clk);
    check("blk1_release", {31'b0, b_crr[0]}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
